// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; data has priority with a starvation guard for fetch.
// Grants same cycle as memory accepts, responses forwarded combinationally; one transaction outstanding, stalls while imem_ready=0.
module mem_port_arbiter #(
    parameter int MP_DATA_WIDTH   = 32,
    parameter int MP_ADDR_WIDTH   = 32,
    parameter int MP_BE_WIDTH     = 2,
    parameter int MP_STARVE_LIMIT = 4
) (
    input  logic                     iclk,
    input  logic                     irst,
    input  logic                     ifetch_req,
    input  logic [MP_ADDR_WIDTH-1:0] ifetch_addr,
    output logic                     ofetch_gnt,
    output logic                     ofetch_rvalid,
    output logic [MP_DATA_WIDTH-1:0] ofetch_rdata,
    input  logic                     idata_req,
    input  logic                     idata_we,
    input  logic [MP_BE_WIDTH-1:0]   idata_be,
    input  logic [MP_ADDR_WIDTH-1:0] idata_addr,
    input  logic [MP_DATA_WIDTH-1:0] idata_wdata,
    output logic                     odata_gnt,
    output logic                     odata_rvalid,
    output logic [MP_DATA_WIDTH-1:0] odata_rdata,
    output logic                     omem_req,
    output logic                     omem_we,
    output logic [MP_BE_WIDTH-1:0]   omem_be,
    output logic [MP_ADDR_WIDTH-1:0] omem_addr,
    output logic [MP_DATA_WIDTH-1:0] omem_wdata,
    input  logic                     imem_ready,
    input  logic                     imem_rvalid,
    input  logic [MP_DATA_WIDTH-1:0] imem_rdata,
    output logic                     obusy
);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    localparam logic [3:0] LIMIT = 4'(MP_STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       store_q, store_d;
    logic       data_win;

    assign data_win = idata_req && !(ifetch_req && (starve_q == LIMIT));
    assign obusy    = (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        store_d       = store_q;
        ofetch_gnt    = 1'b0;
        ofetch_rvalid = 1'b0;
        ofetch_rdata  = '0;
        odata_gnt     = 1'b0;
        odata_rvalid  = 1'b0;
        odata_rdata   = '0;
        omem_req      = 1'b0;
        omem_we       = 1'b0;
        omem_be       = '0;
        omem_addr     = '0;
        omem_wdata    = '0;
        if (!irst) begin
            case (state_q)
                IDLE: begin
                    omem_req = ifetch_req | idata_req;
                    if (data_win) begin
                        omem_we    = idata_we;
                        omem_be    = idata_be;
                        omem_addr  = idata_addr;
                        omem_wdata = idata_wdata;
                    end else if (ifetch_req) begin
                        omem_addr = ifetch_addr;
                    end
                    if (omem_req && imem_ready) begin
                        if (data_win) begin
                            odata_gnt = 1'b1;
                            state_d   = WAIT_D;
                            store_d   = idata_we;
                            // Only wins over a waiting fetch count toward starvation.
                            if (ifetch_req && (starve_q < LIMIT))
                                starve_d = starve_q + 4'd1;
                        end else begin
                            ofetch_gnt = 1'b1;
                            state_d    = WAIT_I;
                            starve_d   = 4'd0;
                        end
                    end
                end
                WAIT_I: begin
                    if (imem_rvalid) begin
                        ofetch_rvalid = 1'b1;
                        ofetch_rdata  = imem_rdata;
                        state_d       = IDLE;
                    end
                end
                WAIT_D: begin
                    if (imem_rvalid) begin
                        odata_rvalid = 1'b1;
                        odata_rdata  = store_q ? '0 : imem_rdata;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
            store_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            store_q  <= store_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants, responses, starvation guard, stalls and reset recovery.
module tb_mem_port_arbiter;

    logic        iclk = 1'b0;
    logic        irst;
    logic        ifetch_req;
    logic [31:0] ifetch_addr;
    logic        ofetch_gnt, ofetch_rvalid;
    logic [31:0] ofetch_rdata;
    logic        idata_req, idata_we;
    logic [1:0]  idata_be;
    logic [31:0] idata_addr, idata_wdata;
    logic        odata_gnt, odata_rvalid;
    logic [31:0] odata_rdata;
    logic        omem_req, omem_we;
    logic [1:0]  omem_be;
    logic [31:0] omem_addr, omem_wdata;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        obusy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32), .MP_BE_WIDTH(2), .MP_STARVE_LIMIT(4)
    ) dut (
        .iclk(iclk), .irst(irst),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
        .ofetch_gnt(ofetch_gnt), .ofetch_rvalid(ofetch_rvalid), .ofetch_rdata(ofetch_rdata),
        .idata_req(idata_req), .idata_we(idata_we), .idata_be(idata_be),
        .idata_addr(idata_addr), .idata_wdata(idata_wdata),
        .odata_gnt(odata_gnt), .odata_rvalid(odata_rvalid), .odata_rdata(odata_rdata),
        .omem_req(omem_req), .omem_we(omem_we), .omem_be(omem_be),
        .omem_addr(omem_addr), .omem_wdata(omem_wdata),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .obusy(obusy)
    );

    always #5 iclk = ~iclk;

    // Inputs change 1 time unit after the rising edge, outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic quiet_inputs();
        irst = 1'b0; ifetch_req = 1'b0; ifetch_addr = '0;
        idata_req = 1'b0; idata_we = 1'b0; idata_be = '0; idata_addr = '0; idata_wdata = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    endtask

    task automatic pulse_reset();
        quiet_inputs();
        irst = 1'b1;
        tick();
        irst = 1'b0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        irst = 1'b1; ifetch_req = 1'b1; idata_req = 1'b1; imem_ready = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        tick(); tick();
        #1;
        n_checks++;
        if ({ofetch_gnt, odata_gnt, omem_req, ofetch_rvalid, odata_rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_forced: gnt/req/rvalid=%b required 00000",
                     {ofetch_gnt, odata_gnt, omem_req, ofetch_rvalid, odata_rvalid});
        end
        quiet_inputs();
        tick();
        #1;
        n_checks++;
        if (obusy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: obusy=%b required 0", obusy);
        end
    endtask

    task automatic test_fetch_only();
        quiet_inputs();
        ifetch_req = 1'b1; ifetch_addr = 32'h0000_0010; imem_ready = 1'b1;
        #1;
        n_checks++;
        if ({ofetch_gnt, odata_gnt, omem_req, omem_we} !== 4'b1010 || omem_addr !== 32'h10
            || omem_wdata !== 32'h0 || omem_be !== 2'b00) begin
            n_fail++;
            $display("FAIL fetch_grant: fg=%b dg=%b req=%b we=%b addr=%h be=%b wd=%h required 1 0 1 0 00000010 00 0",
                     ofetch_gnt, odata_gnt, omem_req, omem_we, omem_addr, omem_be, omem_wdata);
        end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        #1;
        n_checks++;
        if (ofetch_rvalid !== 1'b1 || ofetch_rdata !== 32'h0050_0093 || odata_rvalid !== 1'b0
            || odata_rdata !== 32'h0 || ofetch_gnt !== 1'b0 || omem_req !== 1'b0 || obusy !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_resp: frv=%b frd=%h drv=%b drd=%h fg=%b req=%b busy=%b required 1 00500093 0 0 0 0 1",
                     ofetch_rvalid, ofetch_rdata, odata_rvalid, odata_rdata, ofetch_gnt, omem_req, obusy);
        end
        tick();
        imem_rvalid = 1'b0; imem_rdata = '0;
        #1;
        n_checks++;
        if (ofetch_gnt !== 1'b1 || obusy !== 1'b0) begin
            n_fail++; $display("FAIL fetch_regrant: fg=%b busy=%b required 1 0", ofetch_gnt, obusy);
        end
        tick();
        ifetch_req = 1'b0; imem_rvalid = 1'b1;
        tick();
        quiet_inputs();
    endtask

    task automatic test_starvation();
        logic [9:0] exp_fetch;
        exp_fetch = 10'b1000010000;
        pulse_reset();
        ifetch_req = 1'b1; ifetch_addr = 32'h100;
        idata_req = 1'b1; idata_addr = 32'h200; imem_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            imem_rvalid = 1'b0;
            #1;
            n_checks++;
            if (ofetch_gnt !== exp_fetch[k] || odata_gnt !== !exp_fetch[k]) begin
                n_fail++;
                $display("FAIL starve_seq[%0d]: fg=%b dg=%b required fg=%b", k, ofetch_gnt, odata_gnt, exp_fetch[k]);
            end
            tick();
            imem_rvalid = 1'b1; imem_rdata = 32'(k + 32'hA0);
            #1;
            n_checks++;
            if (ofetch_rvalid !== exp_fetch[k] || odata_rvalid !== !exp_fetch[k]
                || (exp_fetch[k] ? ofetch_rdata : odata_rdata) !== 32'(k + 32'hA0)
                || ofetch_gnt !== 1'b0 || odata_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL starve_resp[%0d]: frv=%b drv=%b frd=%h drd=%h fg=%b dg=%b required frv=%b rdata %h, no gnt",
                         k, ofetch_rvalid, odata_rvalid, ofetch_rdata, odata_rdata, ofetch_gnt, odata_gnt,
                         exp_fetch[k], 32'(k + 32'hA0));
            end
            tick();
        end
        quiet_inputs();
    endtask

    task automatic test_store();
        pulse_reset();
        ifetch_req = 1'b1; ifetch_addr = 32'h300;
        idata_req = 1'b1; idata_we = 1'b1; idata_be = 2'b10;
        idata_addr = 32'h40; idata_wdata = 32'hDEAD_BEEF; imem_ready = 1'b1;
        #1;
        n_checks++;
        if (omem_req !== 1'b1 || omem_we !== 1'b1 || omem_be !== 2'b10 || omem_addr !== 32'h40
            || omem_wdata !== 32'hDEAD_BEEF || odata_gnt !== 1'b1 || ofetch_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL store_issue: req=%b we=%b be=%b addr=%h wd=%h dg=%b fg=%b required 1 1 10 00000040 deadbeef 1 0",
                     omem_req, omem_we, omem_be, omem_addr, omem_wdata, odata_gnt, ofetch_gnt);
        end
        tick();
        idata_req = 1'b0; idata_we = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h5555_AAAA;
        #1;
        n_checks++;
        if (odata_rvalid !== 1'b1 || odata_rdata !== 32'h0 || ofetch_gnt !== 1'b0 || ofetch_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_ack: drv=%b drd=%h fg=%b frv=%b required 1 0 0 0",
                     odata_rvalid, odata_rdata, ofetch_gnt, ofetch_rvalid);
        end
        tick();
        quiet_inputs();
    endtask

    task automatic test_stall();
        pulse_reset();
        ifetch_req = 1'b1; ifetch_addr = 32'h500;
        idata_req = 1'b1; idata_addr = 32'h600; imem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (ofetch_gnt !== 1'b0 || odata_gnt !== 1'b0 || omem_req !== 1'b1 || omem_addr !== 32'h600) begin
                n_fail++;
                $display("FAIL stall_nogrant[%0d]: fg=%b dg=%b req=%b addr=%h required 0 0 1 00000600",
                         c, ofetch_gnt, odata_gnt, omem_req, omem_addr);
            end
            tick();
        end
        imem_ready = 1'b1;
        // Counter must still be 0: four data grants precede the first fetch grant.
        for (int k = 0; k < 5; k++) begin
            imem_rvalid = 1'b0;
            #1;
            n_checks++;
            if (odata_gnt !== (k < 4) || ofetch_gnt !== (k == 4)) begin
                n_fail++;
                $display("FAIL stall_after[%0d]: dg=%b fg=%b required dg=%b fg=%b",
                         k, odata_gnt, ofetch_gnt, k < 4, k == 4);
            end
            tick();
            imem_rvalid = 1'b1;
            tick();
        end
        quiet_inputs();
    endtask

    task automatic test_starve_hold();
        pulse_reset();
        idata_req = 1'b1; idata_addr = 32'h700; imem_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            ifetch_req = (k < 4) || (k == 6);
            imem_rvalid = 1'b0;
            #1;
            n_checks++;
            if (odata_gnt !== (k < 6) || ofetch_gnt !== (k == 6)) begin
                n_fail++;
                $display("FAIL starve_hold[%0d]: dg=%b fg=%b required dg=%b fg=%b",
                         k, odata_gnt, ofetch_gnt, k < 6, k == 6);
            end
            tick();
            imem_rvalid = 1'b1;
            tick();
        end
        quiet_inputs();
    endtask

    task automatic test_reset_in_wait();
        pulse_reset();
        idata_req = 1'b1; idata_addr = 32'h800; imem_ready = 1'b1;
        #1;
        n_checks++;
        if (odata_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rstwait_grant: dg=%b required 1", odata_gnt);
        end
        tick();
        idata_req = 1'b0; irst = 1'b1;
        tick();
        irst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        #1;
        n_checks++;
        if (obusy !== 1'b0 || odata_rvalid !== 1'b0 || ofetch_rvalid !== 1'b0 || odata_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rstwait_drop: busy=%b drv=%b frv=%b drd=%h required 0 0 0 0",
                     obusy, odata_rvalid, ofetch_rvalid, odata_rdata);
        end
        tick();
        imem_rvalid = 1'b0; ifetch_req = 1'b1; ifetch_addr = 32'h900;
        #1;
        n_checks++;
        if (ofetch_gnt !== 1'b1 || omem_addr !== 32'h900) begin
            n_fail++; $display("FAIL rstwait_fetch: fg=%b addr=%h required 1 00000900", ofetch_gnt, omem_addr);
        end
        tick();
        ifetch_req = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
        #1;
        n_checks++;
        if (ofetch_rvalid !== 1'b1 || ofetch_rdata !== 32'h1111_2222) begin
            n_fail++;
            $display("FAIL rstwait_fresp: frv=%b frd=%h required 1 11112222", ofetch_rvalid, ofetch_rdata);
        end
        tick();
        quiet_inputs();
    endtask

    task automatic test_spurious_rvalid();
        quiet_inputs();
        imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        #1;
        n_checks++;
        if (ofetch_rvalid !== 1'b0 || odata_rvalid !== 1'b0 || ofetch_rdata !== 32'h0
            || odata_rdata !== 32'h0 || omem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_fwd: frv=%b drv=%b frd=%h drd=%h req=%b required all 0",
                     ofetch_rvalid, odata_rvalid, ofetch_rdata, odata_rdata, omem_req);
        end
        tick();
        #1;
        n_checks++;
        if (obusy !== 1'b0) begin
            n_fail++; $display("FAIL spurious_state: obusy=%b required 0", obusy);
        end
        quiet_inputs();
    endtask

    initial begin
        quiet_inputs();
        #1;
        test_reset();
        test_fetch_only();
        test_starvation();
        test_store();
        test_stall();
        test_starve_hold();
        test_reset_in_wait();
        test_spurious_rvalid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates a single shared memory port between the core's instruction-fetch requester and its load/store requester. This lets the processor run from one unified instruction/data memory instead of split memories. Only one transaction is outstanding at a time. Data accesses have fixed priority, and a starvation guard forces a fetch grant after a bounded number of consecutive data wins.

Parameters:
- MP_DATA_WIDTH, 32: data bus width.
- MP_ADDR_WIDTH, 32: byte address width.
- MP_BE_WIDTH, 2: write byte-enable code width; the arbiter treats it as opaque.
- MP_STARVE_LIMIT, 4: consecutive data wins over a pending fetch before fetch is forced; legal range 1..15.

Ports:
- iclk  in  1  clock
- irst  in  1  synchronous active-high reset
- ifetch_req  in  1  fetch request
- ifetch_addr  in  MP_ADDR_WIDTH  fetch address
- ofetch_gnt  out  1  fetch accepted this cycle
- ofetch_rvalid  out  1  fetch read data valid
- ofetch_rdata  out  MP_DATA_WIDTH  fetch read data
- idata_req  in  1  load/store request
- idata_we  in  1  1 = store
- idata_be  in  MP_BE_WIDTH  store byte-enable code
- idata_addr  in  MP_ADDR_WIDTH  load/store address
- idata_wdata  in  MP_DATA_WIDTH  store data
- odata_gnt  out  1  load/store accepted this cycle
- odata_rvalid  out  1  load data valid / store acknowledged
- odata_rdata  out  MP_DATA_WIDTH  load data
- omem_req  out  1  memory request
- omem_we  out  1  memory write enable
- omem_be  out  MP_BE_WIDTH  memory byte-enable code
- omem_addr  out  MP_ADDR_WIDTH  memory address
- omem_wdata  out  MP_DATA_WIDTH  memory write data
- imem_ready  in  1  memory can accept a request this cycle
- imem_rvalid  in  1  response (read data or write ack) valid
- imem_rdata  in  MP_DATA_WIDTH  memory read data
- obusy  out  1  transaction outstanding (state != IDLE)

Behaviour:
- Clock and reset: one clock domain; irst is synchronous and active-high.
- FSM states: IDLE, WAIT_I, WAIT_D. Reset value: IDLE, starvation counter 0.
- While irst is high, every gnt, rvalid and omem_req output is forced to 0 that cycle.
- IDLE, request presentation:
  - omem_req = ifetch_req | idata_req.
  - The winner's addr/we/be/wdata are driven combinationally onto the omem_* fields.
  - For a fetch, omem_we = 0 and omem_be/omem_wdata = 0.
  - With no request, all omem_* outputs are 0.
- IDLE, winner selection:
  - Data wins, unless ifetch_req=1 and starve_cnt == MP_STARVE_LIMIT; then fetch wins.
- IDLE, grant (memory accepts when omem_req & imem_ready):
  - Assert the winner's gnt in the same cycle.
  - Next state: WAIT_I or WAIT_D.
  - imem_ready=0: no gnt, state and counter unchanged.
- Starvation counter:
  - Data granted while ifetch_req=1: starve_cnt += 1, saturating at MP_STARVE_LIMIT.
  - Fetch granted: starve_cnt cleared.
  - Data granted with no fetch pending: counter unchanged.
- WAIT_x:
  - omem_req = 0; all gnts = 0.
  - On imem_rvalid, forward combinationally to the owner's rvalid, with rdata = imem_rdata. The non-owner's rvalid stays 0.
  - Return to IDLE on that same cycle's edge.
  - Minimum issue spacing: one transaction per 2 cycles.
- Both rdata outputs are 0 whenever the corresponding rvalid is 0.
- Stores complete like reads: odata_rvalid pulses on the ack, and odata_rdata is 0 for stores.
- Requester rules:
  - A requester holds req and its attributes stable until gnt.
  - Dropping req before gnt is legal and leaves no side effect.
  - A requester may re-request in the cycle its rvalid arrives; it will be granted no earlier than the next cycle.
- Boundary cases:
  - imem_rvalid in IDLE (spurious, or a late response after reset) is ignored and never forwarded.
  - Reset during WAIT_x: next state IDLE, counter 0, and the outstanding response is dropped.
  - Simultaneous requests with imem_ready=0 in every cycle: no grant, no counter change.
  - MP_STARVE_LIMIT reached with no fetch pending: data continues to win; counter holds at limit until a fetch is granted.
- obusy = 1 in WAIT_I/WAIT_D, else 0; reset value 0.

Test Plan:
1. Fetch only, addr 0x0000_0010, imem_ready=1, rvalid one cycle later with rdata 0x0050_0093 -> ofetch_gnt at cycle 0; ofetch_rvalid=1 with rdata 0x0050_0093 at cycle 1; odata_* stay 0; next grant possible at cycle 2.
2. Both requesters held high, MP_STARVE_LIMIT=4, memory responds after 1 cycle -> grant sequence D,D,D,D,I,D,D,D,D,I; starve_cnt reaches 4 and clears on each fetch grant.
3. Store we=1, be=2'b10, addr 0x40, wdata 0xDEAD_BEEF, with fetch also pending -> omem_we=1, omem_be=2'b10, omem_addr=0x40, omem_wdata=0xDEAD_BEEF; ack gives odata_rvalid=1, odata_rdata=0; ofetch_gnt=0 in that cycle.
4. Both requests held, imem_ready=0 for 3 cycles then 1 -> no gnt for 3 cycles, starve_cnt unchanged; data granted on cycle 3.
5. Reset pulsed in WAIT_D before any response, then imem_rvalid=1 one cycle after reset -> state IDLE, obusy=0, neither rvalid asserted; a following fetch is granted normally.
6. imem_rvalid=1 with rdata 0x1234_5678 while IDLE and no requests -> both rvalid outputs remain 0 and the state stays IDLE.
